// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/half/word loads and stores into word accesses on an
// async-read, negedge-write data memory; sub-word stores use read-modify-write.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH+1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  MemWrite_o,
    output logic                  MemRead_o,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2;
    logic [1:0] state, sz, lane;
    logic uns, st, acc, bad;
    logic [15:0] wd, hsel;
    logic [7:0] bsel;
    logic [DATA_WIDTH-1:0] ld_val, merged;
    assign ready = state == IDLE;
    assign acc = req_valid && ready && (MemRead || MemWrite);
    assign bad = (MemRead && MemWrite) || size == 2'b11 || (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
    always_comb begin
        bsel = mem_q[8*lane +: 8];
        hsel = lane[1] ? mem_q[31:16] : mem_q[15:0];
        ld_val = sz == 2'b00 ? {{(DATA_WIDTH-8){bsel[7] & ~uns}}, bsel} :
                 sz == 2'b01 ? {{(DATA_WIDTH-16){hsel[15] & ~uns}}, hsel} : mem_q;
        merged = mem_q;
        if (sz == 2'b00) merged[8*lane +: 8] = wd[7:0];
        else merged[16*lane[1] +: 16] = wd;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sz <= 2'b00;
            lane <= 2'b00;
            uns <= 1'b0;
            st <= 1'b0;
            wd <= '0;
            rdata <= '0;
            rdata_valid <= 1'b0;
            err <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            MemWrite_o <= 1'b0;
            MemRead_o <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            err <= 1'b0;
            MemRead_o <= 1'b0;
            MemWrite_o <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    if (bad) err <= 1'b1;
                    else begin
                        mem_addr <= addr[ADDR_WIDTH+1:2];
                        sz <= size;
                        lane <= addr[1:0];
                        uns <= unsigned_ld;
                        st <= MemWrite;
                        wd <= wdata[15:0];
                        // word stores skip the read; everything else reads the old word first
                        if (MemWrite && size == 2'b10) begin
                            state <= WRITE;
                            MemWrite_o <= 1'b1;
                            mem_data <= wdata;
                        end else begin
                            state <= READ;
                            MemRead_o <= 1'b1;
                        end
                    end
                end
                READ: if (st) begin
                    state <= WRITE;
                    MemWrite_o <= 1'b1;
                    mem_data <= merged;
                end else begin
                    state <= IDLE;
                    rdata <= ld_val;
                    rdata_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
